// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio and parity helper.
// Used by both the transmitter and the parity-checking receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB first, parity bit, stop bit.
// Latency: tx falls one cycle after tx_start is accepted; frame lasts (DBIT+2)*16+SB_TICK ticks.
// Backpressure: tx_start is honoured only in idle; requests while busy are dropped, not queued.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

    uart_state_t     state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            p_reg, p_next;
    logic            tx_reg, tx_next;
    logic [7:0]      din_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        p_next       = p_reg;
        tx_done_tick = 1'b0;
        din_ext      = '0;
        din_ext[DBIT-1:0] = din;

        case (state_reg)
            ST_IDLE: begin
                // A tick arriving with the start request is not part of the start bit.
                if (tx_start) begin
                    b_next     = din;
                    p_next     = uart_parity(din_ext, PARITY_ODD != 0);
                    s_next     = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_reg == LAST_TICK) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == LAST_TICK) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == LAST_BIT) begin
                            state_next = ST_PARITY;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_reg == LAST_TICK) begin
                        s_next     = '0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Line level follows the next state so tx stays aligned with the state register.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = b_next[0];
            ST_PARITY: tx_next = p_next;
            default:   tx_next = 1'b1;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state_reg != ST_IDLE);

endmodule
